// File: rtl/inst_encoder_loader.sv
// Packs decoder-layout instruction fields into words and streams them into instruction memory.
// Optional: define INST_PARITY_EN to place even parity over bits [15:5] in the top bit.
module inst_encoder_loader #(
   parameter int DATAPATH_WIDTH = 64,
   parameter int INST_MEM_ADDR  = 9,
   parameter int REGFILE_ADDR   = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic [INST_MEM_ADDR-1:0]  base_addr,
   input  logic [INST_MEM_ADDR-1:0]  count,
   input  logic                      fld_valid,
   output logic                      fld_ready,
   input  logic                      fld_wmem,
   input  logic                      fld_wreg,
   input  logic [REGFILE_ADDR-1:0]   fld_r0,
   input  logic [REGFILE_ADDR-1:0]   fld_r1,
   input  logic [REGFILE_ADDR-1:0]   fld_wreg1,
   output logic                      mem_we,
   output logic [INST_MEM_ADDR-1:0]  mem_addr,
   output logic [DATAPATH_WIDTH-1:0] mem_wdata,
   output logic                      busy,
   output logic                      done,
   output logic                      wrap
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   state_t                      state_reg, state_next;
   logic [INST_MEM_ADDR-1:0]    ptr_reg, rem_reg;
   logic                        wrap_reg, mem_we_reg;
   logic [INST_MEM_ADDR-1:0]    mem_addr_reg;
   logic [DATAPATH_WIDTH-1:0]   mem_wdata_reg;
   logic [DATAPATH_WIDTH-1:0]   enc_word;
   logic                        transfer;

   assign transfer = (state_reg == LOAD) && fld_valid;

   // Field placement must track the decoder's extraction layout exactly.
   always_comb begin
      enc_word        = '0;
      enc_word[15]    = fld_wmem;
      enc_word[14]    = fld_wreg;
      enc_word[13:11] = fld_r0;
      enc_word[10:8]  = fld_r1;
      enc_word[7:5]   = fld_wreg1;
`ifdef INST_PARITY_EN
      enc_word[DATAPATH_WIDTH-1] = ^enc_word[15:5];
`else
      enc_word[DATAPATH_WIDTH-1] = 1'b0;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: if (start) state_next = (count == '0) ? DONE : LOAD;
         LOAD: if (transfer && rem_reg == INST_MEM_ADDR'(1)) state_next = DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      fld_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_reg)
         LOAD: begin
            fld_ready = 1'b1;
            busy      = 1'b1;
         end
         DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_reg       <= '0;
         rem_reg       <= '0;
         wrap_reg      <= 1'b0;
         mem_we_reg    <= 1'b0;
         mem_addr_reg  <= '0;
         mem_wdata_reg <= '0;
      end else begin
         mem_we_reg <= transfer;
         if (state_reg == IDLE && start) begin
            ptr_reg  <= base_addr;
            rem_reg  <= count;
            wrap_reg <= 1'b0;
         end
         if (transfer) begin
            mem_addr_reg  <= ptr_reg;
            mem_wdata_reg <= enc_word;
            ptr_reg       <= ptr_reg + INST_MEM_ADDR'(1);
            rem_reg       <= rem_reg - INST_MEM_ADDR'(1);
            // Only flag a wrap when another write will actually land at address 0.
            if ((&ptr_reg) && rem_reg > INST_MEM_ADDR'(1)) wrap_reg <= 1'b1;
         end
      end
   end

   assign mem_we    = mem_we_reg;
   assign mem_addr  = mem_addr_reg;
   assign mem_wdata = mem_wdata_reg;
   assign wrap      = wrap_reg;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: load, gaps, wrap, zero count, abort, parity.
module tb_inst_encoder_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  base_addr = '0;
   logic [8:0]  count = '0;
   logic        fld_valid = 1'b0;
   logic        fld_ready;
   logic        fld_wmem = 1'b0;
   logic        fld_wreg = 1'b0;
   logic [2:0]  fld_r0 = '0;
   logic [2:0]  fld_r1 = '0;
   logic [2:0]  fld_wreg1 = '0;
   logic        mem_we;
   logic [8:0]  mem_addr;
   logic [63:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        wrap;

   int errors = 0;
   int checks = 0;

`ifdef INST_PARITY_EN
   localparam logic [63:0] PBIT = 64'h8000_0000_0000_0000;
`else
   localparam logic [63:0] PBIT = 64'h0;
`endif
   // Hand-encoded tuples; the parity bit is added only for odd-weight tuples.
   localparam logic [63:0] W_A  = 64'h0000_0000_0000_9DE0;         // (1,0,3,5,7), 8 ones
   localparam logic [63:0] W_B  = 64'h0000_0000_0000_4A80;         // (0,1,1,2,4), 4 ones
   localparam logic [63:0] W_T0 = 64'h0000_0000_0000_DDE0 | PBIT;  // (1,1,3,5,7), 9 ones
   localparam logic [63:0] W_T1 = 64'h0000_0000_0000_0020 | PBIT;  // (0,0,0,0,1), 1 one
   localparam logic [63:0] W_T2 = 64'h0000_0000_0000_B800;         // (1,0,7,0,0), 4 ones

   inst_encoder_loader dut (
      .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .count(count),
      .fld_valid(fld_valid), .fld_ready(fld_ready), .fld_wmem(fld_wmem), .fld_wreg(fld_wreg),
      .fld_r0(fld_r0), .fld_r1(fld_r1), .fld_wreg1(fld_wreg1), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done), .wrap(wrap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_fld(input logic wm, input logic wr, input logic [2:0] a,
                          input logic [2:0] b, input logic [2:0] d);
      fld_wmem = wm; fld_wreg = wr; fld_r0 = a; fld_r1 = b; fld_wreg1 = d;
   endtask

   // Write port, control flags and pulse outputs checked together each cycle.
   task automatic chk_wr(input string tag, input logic we, input logic [8:0] a,
                         input logic [63:0] d);
      chk({tag, "_we"}, 64'(mem_we), 64'(we));
      if (we) begin
         chk({tag, "_addr"}, 64'(mem_addr), 64'(a));
         chk({tag, "_data"}, mem_wdata, d);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic rdy, input logic bsy, input logic dn);
      chk({tag, "_ready"}, 64'(fld_ready), 64'(rdy));
      chk({tag, "_busy"}, 64'(busy), 64'(bsy));
      chk({tag, "_done"}, 64'(done), 64'(dn));
   endtask

   initial begin
      // Reset state
      step(); step();
      chk_ctl("rst", 1'b0, 1'b0, 1'b0);
      chk("rst_we", 64'(mem_we), 64'd0);
      chk("rst_wrap", 64'(wrap), 64'd0);
      chk("rst_addr", 64'(mem_addr), 64'd0);
      chk("rst_data", mem_wdata, 64'd0);
      reset = 1'b0;

      // Basic load, two tuples back to back
      start = 1'b1; base_addr = 9'h010; count = 9'd2; fld_valid = 1'b1;
      set_fld(1'b1, 1'b0, 3'd3, 3'd5, 3'd7);
      step(); start = 1'b0;
      chk_ctl("b_load", 1'b1, 1'b1, 1'b0);
      chk_wr("b_c1", 1'b0, 9'h0, 64'h0);
      step(); set_fld(1'b0, 1'b1, 3'd1, 3'd2, 3'd4);
      chk_wr("b_w0", 1'b1, 9'h010, W_A);
      chk_ctl("b_w0", 1'b1, 1'b1, 1'b0);
      step(); fld_valid = 1'b0;
      chk_wr("b_w1", 1'b1, 9'h011, W_B);
      chk_ctl("b_w1", 1'b0, 1'b1, 1'b1);
      step();
      chk_wr("b_end", 1'b0, 9'h0, 64'h0);
      chk_ctl("b_end", 1'b0, 1'b0, 1'b0);

      // Backpressure gaps: valid 1,0,1,0,1
      start = 1'b1; base_addr = 9'h020; count = 9'd3;
      step(); start = 1'b0;
      fld_valid = 1'b1; set_fld(1'b1, 1'b1, 3'd3, 3'd5, 3'd7);
      step(); fld_valid = 1'b0; set_fld(1'b1, 1'b1, 3'd7, 3'd7, 3'd7);
      chk_wr("g_w0", 1'b1, 9'h020, W_T0);
      step(); fld_valid = 1'b1; set_fld(1'b0, 1'b0, 3'd0, 3'd0, 3'd1);
      chk_wr("g_gap0", 1'b0, 9'h0, 64'h0);
      step(); fld_valid = 1'b0; set_fld(1'b1, 1'b1, 3'd7, 3'd7, 3'd7);
      chk_wr("g_w1", 1'b1, 9'h021, W_T1);
      step(); fld_valid = 1'b1; set_fld(1'b1, 1'b0, 3'd7, 3'd0, 3'd0);
      chk_wr("g_gap1", 1'b0, 9'h0, 64'h0);
      chk_ctl("g_gap1", 1'b1, 1'b1, 1'b0);
      step(); fld_valid = 1'b0;
      chk_wr("g_w2", 1'b1, 9'h022, W_T2);
      chk_ctl("g_w2", 1'b0, 1'b1, 1'b1);
      step();
      chk_wr("g_end", 1'b0, 9'h0, 64'h0);

      // Address wrap 0x1FF -> 0x000
      start = 1'b1; base_addr = 9'h1FF; count = 9'd2; fld_valid = 1'b1;
      set_fld(1'b0, 1'b0, 3'd0, 3'd0, 3'd1);
      step(); start = 1'b0;
      chk("w_pre", 64'(wrap), 64'd0);
      step();
      chk_wr("w_w0", 1'b1, 9'h1FF, W_T1);
      chk("w_flag0", 64'(wrap), 64'd1);
      step(); fld_valid = 1'b0;
      chk_wr("w_w1", 1'b1, 9'h000, W_T1);
      chk_ctl("w_w1", 1'b0, 1'b1, 1'b1);
      step(); step();
      chk("w_idle", 64'(wrap), 64'd1);

      // Zero count: straight to DONE, stray valid ignored, start clears wrap
      start = 1'b1; base_addr = 9'h050; count = 9'd0; fld_valid = 1'b1;
      step();
      chk_ctl("z_done", 1'b0, 1'b1, 1'b1);
      chk_wr("z_done", 1'b0, 9'h0, 64'h0);
      chk("z_wrap", 64'(wrap), 64'd0);
      step(); start = 1'b0;
      chk_ctl("z_idle", 1'b0, 1'b0, 1'b0);
      chk_wr("z_idle", 1'b0, 9'h0, 64'h0);

      // First IDLE after DONE accepts start; mid-load start ignored; reset aborts
      start = 1'b1; base_addr = 9'h080; count = 9'd4; fld_valid = 1'b1;
      set_fld(1'b1, 1'b0, 3'd7, 3'd0, 3'd0);
      step(); start = 1'b0;
      chk_ctl("r_load", 1'b1, 1'b1, 1'b0);
      step(); start = 1'b1; base_addr = 9'h100; count = 9'd9;
      chk_wr("r_w0", 1'b1, 9'h080, W_T2);
      step(); start = 1'b0;
      chk_wr("r_w1", 1'b1, 9'h081, W_T2);
      chk_ctl("r_w1", 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      step(); reset = 1'b0;
      chk_ctl("r_abort", 1'b0, 1'b0, 1'b0);
      chk("r_abort_we", 64'(mem_we), 64'd0);
      chk("r_abort_addr", 64'(mem_addr), 64'd0);
      chk("r_abort_data", mem_wdata, 64'd0);
      chk("r_abort_wrap", 64'(wrap), 64'd0);
      step();
      chk_ctl("r_after0", 1'b0, 1'b0, 1'b0);
      chk_wr("r_after0", 1'b0, 9'h0, 64'h0);
      step(); fld_valid = 1'b0;
      chk_ctl("r_after1", 1'b0, 1'b0, 1'b0);
      chk_wr("r_after1", 1'b0, 9'h0, 64'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
